// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_share_arbiter: round-robin sharing of one pipelined multiplier among  |
// | NREQ requesters, with a tag pipe that routes each product back.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mult_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTHA   = 16,
  parameter int WIDTHB   = 24,
  parameter int MULT_LAT = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold_i,
  input  logic [NREQ-1:0]               req_valid_i,
  output logic [NREQ-1:0]               req_ready_o,
  input  logic [NREQ*WIDTHA-1:0]        req_a_i,
  input  logic [NREQ*WIDTHB-1:0]        req_b_i,
  output logic [WIDTHA-1:0]             mul_a_o,
  output logic [WIDTHB-1:0]             mul_b_o,
  output logic                          mul_vld_o,
  input  logic [WIDTHA+WIDTHB-1:0]      mul_result_i,
  output logic [NREQ-1:0]               rsp_valid_o,
  output logic [WIDTHA+WIDTHB-1:0]      rsp_data_o,
  output logic [$clog2(NREQ)-1:0]       rsp_id_o,
  output logic [$clog2(MULT_LAT+2)-1:0] inflight_o
);

  localparam int                c_IDW      = $clog2(NREQ);
  localparam int                c_CNTW     = $clog2(MULT_LAT+2);
  localparam logic [c_IDW-1:0]  c_LAST_RST = c_IDW'(NREQ-1);
  localparam logic [NREQ-1:0]   c_REQ_ONE  = 1;
  localparam logic [c_CNTW-1:0] c_CNT_ONE  = 1;

  logic [WIDTHA-1:0] mul_a_q, mul_a_d;
  logic [WIDTHB-1:0] mul_b_q, mul_b_d;
  logic              mul_vld_q, mul_vld_d;
  logic [c_IDW-1:0]  issue_id_q, issue_id_d;
  logic [c_IDW-1:0]  last_grant_q, last_grant_d;
  logic [c_CNTW-1:0] inflight_q, inflight_d;
  logic [MULT_LAT-1:0] tag_vld_q;
  logic [c_IDW-1:0]    tag_id_q [MULT_LAT];

  logic [NREQ-1:0]   w_grant;
  logic [c_IDW-1:0]  w_grant_id;
  logic              w_found;
  logic              w_xfer;
  logic              w_rsp;
  logic [c_IDW-1:0]  w_idx;
  int                w_sum;
  logic [WIDTHA-1:0] w_sel_a;
  logic [WIDTHB-1:0] w_sel_b;

  // Search starts one past the last winner and wraps, so every requester
  // is reached within NREQ grants.
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_found    = 1'b0;
    w_sum      = 0;
    w_idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = int'(last_grant_q) + i + 1;
      if (w_sum >= NREQ) begin
        w_sum = w_sum - NREQ;
      end
      w_idx = c_IDW'(w_sum);
      if (!rst && !hold_i && !w_found && req_valid_i[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_id     = w_idx;
      end
    end
  end

  assign w_xfer  = |w_grant;
  assign w_sel_a = req_a_i[int'(w_grant_id)*WIDTHA +: WIDTHA];
  assign w_sel_b = req_b_i[int'(w_grant_id)*WIDTHB +: WIDTHB];
  assign w_rsp   = tag_vld_q[MULT_LAT-1];

  always_comb begin
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_vld_d    = w_xfer;
    issue_id_d   = issue_id_q;
    last_grant_d = last_grant_q;
    inflight_d   = inflight_q;
    if (w_xfer) begin
      mul_a_d      = w_sel_a;
      mul_b_d      = w_sel_b;
      issue_id_d   = w_grant_id;
      last_grant_d = w_grant_id;
    end
    case ({w_xfer, w_rsp})
      2'b10:   inflight_d = inflight_q + c_CNT_ONE;
      2'b01:   inflight_d = inflight_q - c_CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_vld_q    <= 1'b0;
      issue_id_q   <= '0;
      last_grant_q <= c_LAST_RST;
      inflight_q   <= '0;
    end else begin
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_vld_q    <= mul_vld_d;
      issue_id_q   <= issue_id_d;
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
    end
  end

  // The tag pipe is fed from the operand register stage, so its tail lines
  // up with mul_result exactly MULT_LAT cycles after mul_a/mul_b.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int s = 0; s < MULT_LAT; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_vld_q[0] <= mul_vld_q;
      tag_id_q[0]  <= issue_id_q;
      for (int s = 1; s < MULT_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  assign req_ready_o = w_grant;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_vld_o   = mul_vld_q;
  assign rsp_valid_o = (!rst && w_rsp) ? (c_REQ_ONE << tag_id_q[MULT_LAT-1]) : '0;
  assign rsp_id_o    = tag_id_q[MULT_LAT-1];
  assign rsp_data_o  = mul_result_i;
  assign inflight_o  = inflight_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_o));
  a_ready_valid:  assert property (@(posedge clk) disable iff (rst) (req_ready_o & ~req_valid_i) == '0);
  a_inflight_max: assert property (@(posedge clk) disable iff (rst) int'(inflight_q) <= MULT_LAT + 1);

endmodule
`default_nettype wire
